// File: rtl/bnn_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : bnn_seq_ctrl
// Brief   : Sequencer for a small BNN datapath. It loads weights from a nibble
//           stream and runs one inference at a time.
// Revision: 1.0
// ============================================================================
module bnn_seq_ctrl #(
    parameter int NUM_NEURONS = 12,
    parameter int PIPE_LAT    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       cfg_start,
    input  logic       nib_valid,
    input  logic [3:0] nib_data,
    output logic       nib_ready,
    output logic       wr_en,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] bnn_in,
    input  logic [3:0] res_in,
    output logic       out_valid,
    output logic [3:0] out_data,
    input  logic       out_ready,
    output logic       load_done,
    output logic [7:0] infer_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        INFER = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [3:0] c_last_idx = 4'(NUM_NEURONS - 1);
    localparam logic [7:0] c_lat      = 8'(PIPE_LAT);

    state_t     state_q,     state_d;
    logic [3:0] idx_q,       idx_d;
    logic       phase_q,     phase_d;
    logic [3:0] lo_q,        lo_d;
    logic [7:0] cnt_q,       cnt_d;
    logic       wr_en_q,     wr_en_d;
    logic [3:0] wr_addr_q,   wr_addr_d;
    logic [7:0] wr_data_q,   wr_data_d;
    logic [7:0] bnn_in_q,    bnn_in_d;
    logic       out_valid_q, out_valid_d;
    logic [3:0] out_data_q,  out_data_d;
    logic       load_done_q, load_done_d;
    logic [7:0] infer_cnt_q, infer_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 4'd0;
            phase_q     <= 1'b0;
            lo_q        <= 4'd0;
            cnt_q       <= 8'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 4'd0;
            wr_data_q   <= 8'd0;
            bnn_in_q    <= 8'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 4'd0;
            load_done_q <= 1'b0;
            infer_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            phase_q     <= phase_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            bnn_in_q    <= bnn_in_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            load_done_q <= load_done_d;
            infer_cnt_q <= infer_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        phase_d     = phase_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        wr_en_d     = wr_en_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        bnn_in_d    = bnn_in_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        load_done_d = load_done_q;
        infer_cnt_d = infer_cnt_q;

        // With ena low everything holds, so a pending write/pulse survives the stall.
        if (ena) begin
            wr_en_d     = 1'b0;
            load_done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        state_d = LOAD;
                        idx_d   = 4'd0;
                        phase_d = 1'b0;
                    end else if (in_valid) begin
                        bnn_in_d = in_data;
                        cnt_d    = 8'd0;
                        state_d  = INFER;
                    end
                end
                LOAD: begin
                    if (nib_valid) begin
                        if (!phase_q) begin
                            lo_d    = nib_data;
                            phase_d = 1'b1;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = idx_q;
                            wr_data_d = {nib_data, lo_q};
                            phase_d   = 1'b0;
                            if (idx_q == c_last_idx) begin
                                idx_d       = 4'd0;
                                load_done_d = 1'b1;
                                state_d     = IDLE;
                            end else begin
                                idx_d = idx_q + 4'd1;
                            end
                        end
                    end
                end
                INFER: begin
                    if (cnt_q == c_lat) begin
                        out_data_d  = res_in;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        infer_cnt_d = infer_cnt_q + 8'd1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign nib_ready = ena && (state_q == LOAD);
    assign in_ready  = ena && (state_q == IDLE) && !cfg_start;
    assign wr_en     = wr_en_q && ena;
    assign load_done = load_done_q && ena;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign bnn_in    = bnn_in_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign infer_cnt = infer_cnt_q;

endmodule
`default_nettype wire

// File: doc/bnn_seq_ctrl.md
BNN_SEQ_CTRL -- requirements
Module: bnn_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 12, number of 8-bit weight registers in the weight bank.
REQ-002 SHALL have parameter PIPE_LAT, default 2, number of datapath register stages between bnn_in and res_in.
REQ-003 SHALL have port clk, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous, active-high reset.
REQ-005 SHALL have port ena, input, 1 bit; when low, all state holds and all ready outputs are 0.
REQ-006 SHALL have port cfg_start, input, 1 bit, request to reload all weights.
REQ-007 SHALL have ports nib_valid (input, 1), nib_data (input, 4) and nib_ready (output, 1), forming the weight nibble stream.
REQ-008 SHALL have ports wr_en (output, 1), wr_addr (output, 4) and wr_data (output, 8), forming the weight bank write port.
REQ-009 SHALL have ports in_valid (input, 1), in_data (input, 8) and in_ready (output, 1), forming the inference request.
REQ-010 SHALL have port bnn_in, output, 8 bits, registered input vector driven to the datapath.
REQ-011 SHALL have port res_in, input, 4 bits, layer-2 output of the datapath.
REQ-012 SHALL have ports out_valid (output, 1), out_data (output, 4) and out_ready (input, 1), forming the result stream.
REQ-013 SHALL have port load_done, output, 1 bit, one-cycle pulse when a full reload completes.
REQ-014 SHALL have port infer_cnt, output, 8 bits, count of completed result handshakes.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, INFER and HOLD.
REQ-016 In IDLE with cfg_start=1, SHALL move to LOAD with index=0 and phase=0.
- cfg_start takes priority: in_ready = (state==IDLE) && !cfg_start && ena.
REQ-017 In LOAD, nib_ready SHALL be 1 (if ena), and SHALL be 0 in all other states.
REQ-018 On a LOAD handshake with phase=0, SHALL latch nib_data as the low nibble and set phase=1.
REQ-019 On a LOAD handshake with phase=1, SHALL on the next cycle drive wr_en=1 for exactly one cycle, with wr_addr=index and wr_data={nib_data, low nibble}, then increment index and clear phase.
REQ-020 Writing index NUM_NEURONS-1 SHALL return the FSM to IDLE and pulse load_done in the same cycle as that final wr_en.
REQ-021 cfg_start outside IDLE SHALL be ignored.
REQ-022 A nibble offered outside LOAD SHALL NOT be consumed.
REQ-023 On an IDLE in_valid/in_ready handshake at edge N, SHALL register bnn_in<=in_data, enter INFER and clear the wait counter.
REQ-024 bnn_in SHALL hold its value until the next accepted request.
REQ-025 INFER SHALL count PIPE_LAT+1 cycles, capture res_in into out_data at edge N+PIPE_LAT+1 (N+3 at default), set out_valid=1 and enter HOLD.
REQ-026 In HOLD, out_valid and out_data SHALL be stable until out_ready=1.
- On the handshake: out_valid<=0, infer_cnt increments (wrapping 255->0), FSM returns to IDLE.
REQ-027 No new request SHALL be accepted during INFER or HOLD, giving at most one inference in flight.
REQ-028 ena=0 SHALL freeze the FSM, counters and phase.
- wr_en SHALL be forced to 0 while ena=0.
- A pending write SHALL issue on the first cycle after ena returns high.

Reset
REQ-029 reset SHALL set state=IDLE and index=0, phase=0, wr_en=0, wr_addr=0, wr_data=0, bnn_in=0, out_valid=0, out_data=0, load_done=0 and infer_cnt=0.
REQ-030 reset during LOAD SHALL abandon the partial load; the weight bank is not cleared by this block.
REQ-031 reset during INFER or HOLD SHALL discard the result without incrementing infer_cnt.

Verification
REQ-032 Reload test: cfg_start, then 24 nibbles 0x1,0x2,...,0x8,0x1,... -> 12 wr_en pulses, addr 0..11, wr_data[0]=0x21, wr_data[1]=0x43; load_done coincides with addr 11.
REQ-033 Inference test: in_data=0xA5 with res_in model = bnn_in[3:0] delayed 2 cycles -> out_valid three cycles after the handshake, out_data=0x5, infer_cnt=1.
REQ-034 Backpressure test: out_ready=0 for 10 cycles -> out_valid and out_data stable and in_ready=0 throughout; acceptance of the next request only after the result handshake.
REQ-035 Priority test: cfg_start and in_valid asserted together in IDLE -> in_ready=0, FSM in LOAD, request not consumed.
REQ-036 Reset test: reset asserted after 5 nibbles, then a fresh reload -> first write has wr_addr=0 and uses only post-reset nibbles.
REQ-037 Wrap and ena test: 256 inferences -> infer_cnt=0; ena=0 mid-INFER for 4 cycles -> latency extended by exactly 4 cycles.
